lap_stopwatch: RTL and testbench
================================

# lap_stopwatch

Parametrised stopwatch core: start/stop, pause, clear and lap-hold on an N-digit BCD time count (centiseconds upward), driving a multiplexed common-anode 7-segment display directly. It replaces the fixed-width stopwatch controller beneath the board top level. It takes already-synchronised button levels and does its own edge detection.

## Interface
- TICK_DIV, 1_000_000: clk cycles per 10 ms count tick (100 MHz board); legal ≥2
- SCAN_DIV, 100_000: clk cycles each digit is enabled during display scan; legal ≥1
- NUM_DIGITS, 8: displayed digits, 4..8; digit moduli from LSD: 10,10,10,6,10,6,10,10 (cs, cs-tens, s, s-tens, m, m-tens, h, h-tens)
- clk  in  1  system clock, all logic on rising edge
- resetb  in  1  asynchronous, active-low reset
- start_stop  in  1  synchronised button level, active-high; rising edge toggles run/pause
- lap  in  1  synchronised level; rising edge toggles lap hold
- clear  in  1  synchronised level; rising edge zeroes count (not while running)
- an  out  NUM_DIGITS  digit enables, active-low, one-hot
- cn  out  8  {dp,g,f,e,d,c,b,a}, active-low
- running  out  1  high in RUN
- overflow  out  1  sticky, count wrapped past maximum

## Operation
- Edge detect: each input registered once; event = in & ~in_q. Level held high = one event only.
- States IDLE (count zero), RUN, PAUSE. IDLE -start_stop-> RUN; RUN -start_stop-> PAUSE; PAUSE -start_stop-> RUN; PAUSE -clear-> IDLE.
- clear in RUN ignored. clear in IDLE: releases hold, clears overflow, stays IDLE.
- clear and start_stop events in same cycle in PAUSE: clear wins → IDLE; start_stop dropped.
- Prescaler counts 0..TICK_DIV-1 only in RUN; held (not reset) in PAUSE; zeroed by clear/reset. tick when prescaler = TICK_DIV-1.
- On tick, digit chain increments ripple-carry with per-digit moduli; all digits at max + tick → all zero, overflow set.
- Lap hold: lap event with hold clear, in RUN → capture live count into lap register, hold set; count continues. lap event with hold set (any state) → hold cleared. lap event in IDLE/PAUSE with hold clear ignored.
- Display source = lap register if hold else live count.
- Scan: scan prescaler 0..SCAN_DIV-1, digit index advances 0..NUM_DIGITS-1 then wraps to 0. an low on current index only.
- cn = segment pattern of displayed digit; dp lit on digits 2 and 4 (s and m boundary), where present.

## Timing
- Reset values: state IDLE, counts/lap/prescalers zero, hold 0, running 0, overflow 0, an all ones, cn 8'hFF.
- First edge after reset release: an = ~1 (digit 0), cn = 8'hC0.
- Input event in cycle n (in high, in_q low) → state/hold/count change at end of cycle n; running visible cycle n+1.
- RUN entry: first tick TICK_DIV cycles after running rises (prescaler starting at 0).
- an, cn registered; display reflects count one cycle after count update.
- Reset mid-run: all state to reset values asynchronously; no partial count retained.

## Configuration
- LAP_STOPWATCH_LAP_EN defined: lap register, hold flag and lap input behaviour as above.
- Not defined: no lap register or hold logic; lap input unused; display always live count; clear still releases nothing beyond count/overflow.

## Structure
- Package stopwatch_pkg: state enum (IDLE, RUN, PAUSE), digit modulus constant array, 16-entry BCD-to-segment pattern constant, DP digit positions.
- Sub-module seg7_decoder: 4-bit BCD + dp in, 8-bit active-low cn pattern out, combinational; instantiated once after digit mux.

## Test plan
Bench uses TICK_DIV=4, SCAN_DIV=2, NUM_DIGITS=8.
- Reset release, no input → an cycles 0xFE,0xFE,0xFD,0xFD,…; cn = 0xC0 on digits 0,1,3,5,6,7 and 0x40 on digits 2,4; running 0.
- start_stop pulse, run 400 cycles → count 00:00:01.00 (digit2 = 1, others 0); pulse again, wait 100 cycles, count unchanged; pulse again, resumes with prescaler phase preserved.
- clear pulse while RUN → ignored; in PAUSE simultaneous clear+start_stop → IDLE, count zero, running 0.
- Running, lap pulse at count 0.25 s → display frozen at 00:00:00.25 while live count advances; second lap pulse → display live.
- Preload count 99:59:59.99 via force, one tick → all digits 0, overflow 1; clear in PAUSE → overflow 0.
- Assert resetb low mid-RUN for 1 cycle → an all ones, cn 8'hFF, running 0 immediately; hold cleared.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// ============================================================================
// Module   : stopwatch_pkg
// Brief    : Shared types and constants for the lap_stopwatch core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int MAX_DIGITS = 8;

    // Moduli from the least significant digit: cs, cs-tens, s, s-tens, m, m-tens, h, h-tens
    localparam logic [3:0] DIGIT_MOD [MAX_DIGITS] = '{
        4'd10, 4'd10, 4'd10, 4'd6, 4'd10, 4'd6, 4'd10, 4'd10
    };

    // Active-low {g,f,e,d,c,b,a} for hex values 0..F
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [MAX_DIGITS-1:0] DP_DIGITS = 8'b0001_0100;

endpackage

`default_nettype wire

// File: rtl/seg7_decoder.sv
// ============================================================================
// Module   : seg7_decoder
// Brief    : Combinational BCD + decimal point to active-low segment pattern.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_decoder (
    input  logic [3:0] bcd,
    input  logic       dp,
    output logic [7:0] cn
);
    import stopwatch_pkg::*;

    assign cn = {~dp, SEG_LUT[bcd]};

endmodule

`default_nettype wire

// File: rtl/lap_stopwatch.sv
// ============================================================================
// Module   : lap_stopwatch
// Brief    : BCD stopwatch (run/pause/clear, optional lap hold) driving a
//            multiplexed common-anode 7-segment display.
//            Lap hold is built only when LAP_STOPWATCH_LAP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lap_stopwatch #(
    parameter int TICK_DIV   = 1_000_000,
    parameter int SCAN_DIV   = 100_000,
    parameter int NUM_DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  start_stop,
    input  logic                  lap,
    input  logic                  clear,
    output logic [NUM_DIGITS-1:0] an,
    output logic [7:0]            cn,
    output logic                  running,
    output logic                  overflow
);
    import stopwatch_pkg::*;

    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = 4 * NUM_DIGITS;

    state_t          state_q, state_d;
    logic [TW-1:0]   presc_q, presc_d;
    logic [CW-1:0]   digits_q, digits_d;
    logic            overflow_q, overflow_d;
    logic            running_q, running_d;
    logic            ss_in_q, clr_in_q;
    logic [SW-1:0]   scan_q, scan_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [7:0]      cn_q, cn_d;

    logic            ev_ss, ev_clr, clr_ok, tick, carry;
    logic [CW-1:0]   src;
    logic [3:0]      disp_digit;
    logic [2:0]      dp_idx;

    assign ev_ss  = start_stop & ~ss_in_q;
    assign ev_clr = clear & ~clr_in_q;
    assign clr_ok = ev_clr && (state_q != RUN);
    assign tick   = (state_q == RUN) && (presc_q == TW'(TICK_DIV - 1));

    always_comb begin
        carry      = tick;
        digits_d   = digits_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (digits_q[4*i +: 4] == DIGIT_MOD[i] - 4'd1) begin
                    digits_d[4*i +: 4] = 4'd0;
                end else begin
                    digits_d[4*i +: 4] = digits_q[4*i +: 4] + 4'd1;
                    carry              = 1'b0;
                end
            end
        end
        // A carry surviving the whole chain means every digit was at maximum
        overflow_d = overflow_q | carry;

        presc_d = presc_q;
        if (state_q == RUN) begin
            presc_d = tick ? '0 : presc_q + TW'(1);
        end

        state_d = state_q;
        if (clr_ok) begin
            state_d = IDLE;
        end else if (ev_ss) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end

        if (clr_ok) begin
            digits_d   = '0;
            overflow_d = 1'b0;
            presc_d    = '0;
        end
        running_d = (state_d == RUN);
    end

`ifdef LAP_STOPWATCH_LAP_EN
    logic          lap_in_q, hold_q, hold_d, ev_lap;
    logic [CW-1:0] lap_q, lap_d;

    assign ev_lap = lap & ~lap_in_q;

    always_comb begin
        hold_d = hold_q;
        lap_d  = lap_q;
        if (ev_lap) begin
            if (hold_q) begin
                hold_d = 1'b0;
            end else if (state_q == RUN) begin
                hold_d = 1'b1;
                lap_d  = digits_q;
            end
        end
        if (clr_ok) begin
            hold_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            lap_in_q <= 1'b0;
            hold_q   <= 1'b0;
            lap_q    <= '0;
        end else begin
            lap_in_q <= lap;
            hold_q   <= hold_d;
            lap_q    <= lap_d;
        end
    end

    assign src = hold_q ? lap_q : digits_q;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign src        = digits_q;
`endif

    always_comb begin
        scan_d = scan_q + SW'(1);
        idx_d  = idx_q;
        if (scan_q == SW'(SCAN_DIV - 1)) begin
            scan_d = '0;
            idx_d  = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
        an_d = ~(NUM_DIGITS'(1) << idx_q);
    end

    assign disp_digit = src[{idx_q, 2'b00} +: 4];
    assign dp_idx     = 3'(idx_q);

    seg7_decoder u_seg7_decoder (
        .bcd (disp_digit),
        .dp  (DP_DIGITS[dp_idx]),
        .cn  (cn_d)
    );

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            digits_q   <= '0;
            overflow_q <= 1'b0;
            running_q  <= 1'b0;
            ss_in_q    <= 1'b0;
            clr_in_q   <= 1'b0;
            scan_q     <= '0;
            idx_q      <= '0;
            an_q       <= '1;
            cn_q       <= 8'hFF;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            digits_q   <= digits_d;
            overflow_q <= overflow_d;
            running_q  <= running_d;
            ss_in_q    <= start_stop;
            clr_in_q   <= clear;
            scan_q     <= scan_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            cn_q       <= cn_d;
        end
    end

    assign an       = an_q;
    assign cn       = cn_q;
    assign running  = running_q;
    assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_lap_stopwatch.sv
// ============================================================================
// Module   : tb_lap_stopwatch
// Brief    : Self-checking bench for lap_stopwatch against a centisecond model.
//            Lap expectations follow LAP_STOPWATCH_LAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lap_stopwatch;

    localparam int TICK_DIV   = 4;
    localparam int SCAN_DIV   = 2;
    localparam int NUM_DIGITS = 8;
    localparam int MAXC       = 36_000_000;
`ifdef LAP_STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif
    localparam logic [7:0] SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic clk = 1'b0, resetb = 1'b0, start_stop = 1'b0, lap = 1'b0, clear = 1'b0;
    logic [NUM_DIGITS-1:0] an;
    logic [7:0] cn;
    logic running, overflow;

    int n_tests = 0, n_fail = 0;

    // Reference model: 0 idle, 1 run, 2 pause; count in centiseconds
    int m_state, m_cnt, m_phase, m_lap, m_k;
    bit m_ovf, m_hold, p_ss, p_lap, p_clr;
    logic [7:0] e_an = 8'hFF, e_cn = 8'hFF;
    bit e_run;

    lap_stopwatch #(
        .TICK_DIV   (TICK_DIV),
        .SCAN_DIV   (SCAN_DIV),
        .NUM_DIGITS (NUM_DIGITS)
    ) dut (
        .clk        (clk),
        .resetb     (resetb),
        .start_stop (start_stop),
        .lap        (lap),
        .clear      (clear),
        .an         (an),
        .cn         (cn),
        .running    (running),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bcd(input int c);
        int cs, s, m, h;
        cs = c % 100;
        s  = (c / 100) % 60;
        m  = (c / 6000) % 60;
        h  = (c / 360000) % 100;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
                4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
    endfunction

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_phase = 0; m_lap = 0; m_k = 0;
        m_ovf = 0; m_hold = 0; p_ss = 0; p_lap = 0; p_clr = 0; e_run = 0;
    endtask

    // Advance one clock edge and update the model's expectations
    task automatic step();
        bit es, el, ec;
        int src, idx;
        logic [31:0] sv;
        logic [3:0] dg;
        es  = start_stop && !p_ss;
        el  = lap && !p_lap;
        ec  = clear && !p_clr;
        src = m_hold ? m_lap : m_cnt;
        @(posedge clk);
        m_k++;
        idx  = ((m_k - 1) / SCAN_DIV) % NUM_DIGITS;
        e_an = ~(8'd1 << idx);
        sv   = bcd(src);
        dg   = sv[4*idx +: 4];
        e_cn = SEG[dg] & ((idx == 2 || idx == 4) ? 8'h7F : 8'hFF);
        if (LAP_EN && el) begin
            if (m_hold) m_hold = 0;
            else if (m_state == 1) begin m_hold = 1; m_lap = m_cnt; end
        end
        if (m_state == 1) begin
            if (m_phase == TICK_DIV - 1) begin
                m_phase = 0;
                m_cnt++;
                if (m_cnt == MAXC) begin m_cnt = 0; m_ovf = 1; end
            end else m_phase++;
        end
        if (ec && m_state != 1) begin
            m_state = 0; m_cnt = 0; m_phase = 0; m_ovf = 0; m_hold = 0;
        end else if (es) begin
            m_state = (m_state == 1) ? 2 : 1;
        end
        e_run = (m_state == 1);
        p_ss = start_stop; p_lap = lap; p_clr = clear;
        #1;
    endtask

    task automatic pulse(input bit s, input bit l, input bit c);
        start_stop = s; lap = l; clear = c;
        step();
        start_stop = 0; lap = 0; clear = 0;
        step();
    endtask

    task automatic test_reset();
        resetb = 0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (an !== 8'hFF || cn !== 8'hFF || running !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_vals: got an=%h cn=%h run=%b ovf=%b, expected FF FF 0 0", an, cn, running, overflow);
        end
        resetb = 1;
        model_reset();
        step();
        n_tests++;
        if (an !== 8'hFE || cn !== 8'hC0) begin
            n_fail++;
            $display("FAIL first_edge: got an=%h cn=%h, expected an=FE cn=C0", an, cn);
        end
        for (int i = 0; i < 32; i++) begin
            step();
            n_tests++;
            if (an !== e_an || cn !== e_cn || running !== e_run || overflow !== m_ovf || dut.digits_q !== bcd(m_cnt)) begin
                n_fail++;
                $display("FAIL idle_scan: got an=%h cn=%h run=%b ovf=%b cnt=%h, expected an=%h cn=%h run=%b ovf=%b cnt=%h",
                         an, cn, running, overflow, dut.digits_q, e_an, e_cn, e_run, m_ovf, bcd(m_cnt));
            end
        end
    endtask

    task automatic test_run_pause();
        int wait_n;
        start_stop = 1; step(); start_stop = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            n_tests++;
            if (an !== e_an || cn !== e_cn || running !== e_run || overflow !== m_ovf || dut.digits_q !== bcd(m_cnt)) begin
                n_fail++;
                $display("FAIL run: got an=%h cn=%h run=%b ovf=%b cnt=%h, expected an=%h cn=%h run=%b ovf=%b cnt=%h",
                         an, cn, running, overflow, dut.digits_q, e_an, e_cn, e_run, m_ovf, bcd(m_cnt));
            end
        end
        n_tests++;
        if (dut.digits_q !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL one_second: got cnt=%h, expected 00000100", dut.digits_q);
        end
        start_stop = 1; step(); start_stop = 0;
        wait_n = $urandom_range(50, 150);
        for (int i = 0; i < wait_n; i++) begin
            step();
            n_tests++;
            if (an !== e_an || cn !== e_cn || running !== e_run || overflow !== m_ovf || dut.digits_q !== bcd(m_cnt)) begin
                n_fail++;
                $display("FAIL pause: got an=%h cn=%h run=%b ovf=%b cnt=%h, expected an=%h cn=%h run=%b ovf=%b cnt=%h",
                         an, cn, running, overflow, dut.digits_q, e_an, e_cn, e_run, m_ovf, bcd(m_cnt));
            end
        end
        n_tests++;
        if (dut.digits_q !== 32'h0000_0100 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_hold: got cnt=%h run=%b, expected 00000100 0", dut.digits_q, running);
        end
        // Prescaler was left at phase 1: the third RUN cycle after resuming ticks
        start_stop = 1; step(); start_stop = 0;
        step(); step();
        n_tests++;
        if (dut.digits_q !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL resume_phase_early: got cnt=%h, expected 00000100", dut.digits_q);
        end
        step();
        n_tests++;
        if (dut.digits_q !== 32'h0000_0101) begin
            n_fail++;
            $display("FAIL resume_phase_tick: got cnt=%h, expected 00000101", dut.digits_q);
        end
    endtask

    task automatic test_clear();
        clear = 1; step(); clear = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            n_tests++;
            if (an !== e_an || cn !== e_cn || running !== e_run || overflow !== m_ovf || dut.digits_q !== bcd(m_cnt)) begin
                n_fail++;
                $display("FAIL clear_in_run: got an=%h cn=%h run=%b ovf=%b cnt=%h, expected an=%h cn=%h run=%b ovf=%b cnt=%h",
                         an, cn, running, overflow, dut.digits_q, e_an, e_cn, e_run, m_ovf, bcd(m_cnt));
            end
        end
        n_tests++;
        if (running !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_ignored: got run=%b, expected 1", running);
        end
        pulse(1, 0, 0);
        start_stop = 1; clear = 1; step(); start_stop = 0; clear = 0;
        n_tests++;
        if (running !== 1'b0 || dut.digits_q !== 32'h0) begin
            n_fail++;
            $display("FAIL clear_wins: got run=%b cnt=%h, expected 0 00000000", running, dut.digits_q);
        end
        for (int i = 0; i < 16; i++) begin
            step();
            n_tests++;
            if (an !== e_an || cn !== e_cn || running !== e_run || overflow !== m_ovf || dut.digits_q !== bcd(m_cnt)) begin
                n_fail++;
                $display("FAIL after_clear: got an=%h cn=%h run=%b ovf=%b cnt=%h, expected an=%h cn=%h run=%b ovf=%b cnt=%h",
                         an, cn, running, overflow, dut.digits_q, e_an, e_cn, e_run, m_ovf, bcd(m_cnt));
            end
        end
    endtask

    task automatic test_lap();
        int n;
        start_stop = 1; step(); start_stop = 0;
        for (int i = 0; i < 300 && m_cnt != 25; i++) step();
        n_tests++;
        if (m_cnt != 25 || dut.digits_q !== 32'h0000_0025) begin
            n_fail++;
            $display("FAIL lap_reach: got cnt=%h, expected 00000025", dut.digits_q);
        end
        lap = 1; step(); lap = 0;
        n = $urandom_range(40, 80);
        for (int i = 0; i < n; i++) begin
            step();
            n_tests++;
            if (an !== e_an || cn !== e_cn || running !== e_run || overflow !== m_ovf || dut.digits_q !== bcd(m_cnt)) begin
                n_fail++;
                $display("FAIL lap_hold: got an=%h cn=%h run=%b ovf=%b cnt=%h, expected an=%h cn=%h run=%b ovf=%b cnt=%h",
                         an, cn, running, overflow, dut.digits_q, e_an, e_cn, e_run, m_ovf, bcd(m_cnt));
            end
        end
`ifdef LAP_STOPWATCH_LAP_EN
        begin
            logic [31:0] shown;
            shown = '0;
            for (int i = 0; i < 2 * NUM_DIGITS; i++) begin
                step();
                for (int d = 0; d < 16; d++) begin
                    for (int k = 0; k < NUM_DIGITS; k++) begin
                        if (an == ~(8'd1 << k) && (cn | 8'h80) == SEG[d]) shown[4*k +: 4] = 4'(d);
                    end
                end
            end
            n_tests++;
            if (shown !== 32'h0000_0025) begin
                n_fail++;
                $display("FAIL lap_frozen: got display=%h, expected 00000025", shown);
            end
        end
`endif
        lap = 1; step(); lap = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            n_tests++;
            if (an !== e_an || cn !== e_cn || running !== e_run || overflow !== m_ovf || dut.digits_q !== bcd(m_cnt)) begin
                n_fail++;
                $display("FAIL lap_release: got an=%h cn=%h run=%b ovf=%b cnt=%h, expected an=%h cn=%h run=%b ovf=%b cnt=%h",
                         an, cn, running, overflow, dut.digits_q, e_an, e_cn, e_run, m_ovf, bcd(m_cnt));
            end
        end
        pulse(1, 0, 0);
        lap = 1; step(); lap = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            n_tests++;
            if (an !== e_an || cn !== e_cn || running !== e_run || overflow !== m_ovf || dut.digits_q !== bcd(m_cnt)) begin
                n_fail++;
                $display("FAIL lap_in_pause: got an=%h cn=%h run=%b ovf=%b cnt=%h, expected an=%h cn=%h run=%b ovf=%b cnt=%h",
                         an, cn, running, overflow, dut.digits_q, e_an, e_cn, e_run, m_ovf, bcd(m_cnt));
            end
        end
    endtask

    task automatic test_overflow();
        if (m_state == 1) pulse(1, 0, 0);
        pulse(0, 0, 1);
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        force dut.digits_q = 32'h9959_5999;
        m_cnt = MAXC - 1;
        step();
        release dut.digits_q;
        start_stop = 1; step(); start_stop = 0;
        for (int i = 0; i < 10 && !m_ovf; i++) begin
            step();
            n_tests++;
            if (an !== e_an || cn !== e_cn || running !== e_run || overflow !== m_ovf || dut.digits_q !== bcd(m_cnt)) begin
                n_fail++;
                $display("FAIL near_max: got an=%h cn=%h run=%b ovf=%b cnt=%h, expected an=%h cn=%h run=%b ovf=%b cnt=%h",
                         an, cn, running, overflow, dut.digits_q, e_an, e_cn, e_run, m_ovf, bcd(m_cnt));
            end
        end
        n_tests++;
        if (dut.digits_q !== 32'h0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap: got cnt=%h ovf=%b, expected 00000000 1", dut.digits_q, overflow);
        end
        pulse(1, 0, 0);
        pulse(0, 0, 1);
        n_tests++;
        if (overflow !== 1'b0 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got ovf=%b run=%b, expected 0 0", overflow, running);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0)  start_stop = ~start_stop;
            if ($urandom_range(0, 9) == 0)  lap = ~lap;
            if ($urandom_range(0, 11) == 0) clear = ~clear;
            step();
            n_tests++;
            if (an !== e_an || cn !== e_cn || running !== e_run || overflow !== m_ovf || dut.digits_q !== bcd(m_cnt)) begin
                n_fail++;
                $display("FAIL random: got an=%h cn=%h run=%b ovf=%b cnt=%h, expected an=%h cn=%h run=%b ovf=%b cnt=%h",
                         an, cn, running, overflow, dut.digits_q, e_an, e_cn, e_run, m_ovf, bcd(m_cnt));
            end
        end
        start_stop = 0; lap = 0; clear = 0;
        step(); step();
    endtask

    task automatic test_reset_mid_run();
        if (m_state != 1) pulse(1, 0, 0);
        repeat (30) step();
        if (!m_hold) pulse(0, 1, 0);
        repeat (10) step();
        #2;
        resetb = 0;
        #1;
        n_tests++;
        if (an !== 8'hFF || cn !== 8'hFF || running !== 1'b0 || overflow !== 1'b0 || dut.digits_q !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: got an=%h cn=%h run=%b ovf=%b cnt=%h, expected FF FF 0 0 00000000",
                     an, cn, running, overflow, dut.digits_q);
        end
        @(posedge clk);
        #1;
        resetb = 1;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            step();
            n_tests++;
            if (an !== e_an || cn !== e_cn || running !== e_run || overflow !== m_ovf || dut.digits_q !== bcd(m_cnt)) begin
                n_fail++;
                $display("FAIL post_reset: got an=%h cn=%h run=%b ovf=%b cnt=%h, expected an=%h cn=%h run=%b ovf=%b cnt=%h",
                         an, cn, running, overflow, dut.digits_q, e_an, e_cn, e_run, m_ovf, bcd(m_cnt));
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_run_pause();
        test_clear();
        test_lap();
        test_overflow();
        test_random();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
